// File: rtl/bhg_sar_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bhg_pkg : shared definitions for the bhg SAR ADC controller slice.
//   sar_state_t  - controller state encoding (IDLE, SAMPLE, SETTLE, DECIDE, DONE)
//   SYNC_STAGES  - depth of the comparator synchronizer
//   max2()       - constant-friendly maximum used to size the phase counter
// ---------------------------------------------------------------------------
package bhg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SAMPLE = 3'd1,
    ST_SETTLE = 3'd2,
    ST_DECIDE = 3'd3,
    ST_DONE   = 3'd4
  } sar_state_t;

  localparam int SYNC_STAGES = 2;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bhg_sar_ctrl_if.sv
// ---------------------------------------------------------------------------
// bhg_sar_ctrl_if : signal bundle between the SAR controller and its
// environment (analog macro + digital pins).
//   start, cont, cmp_in          : into the controller
//   sample, dac_code, busy,
//   result, valid                : out of the controller
//   modport slave  - the controller side
//   modport master - the environment / testbench side
// ---------------------------------------------------------------------------
interface bhg_sar_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic             cont;
  logic             cmp_in;
  logic             sample;
  logic [WIDTH-1:0] dac_code;
  logic             busy;
  logic [WIDTH-1:0] result;
  logic             valid;

  modport slave (
    input  start, cont, cmp_in,
    output sample, dac_code, busy, result, valid
  );

  modport master (
    output start, cont, cmp_in,
    input  sample, dac_code, busy, result, valid
  );

endinterface

// File: rtl/bhg_sync2.sv
// ---------------------------------------------------------------------------
// bhg_sync2 : generic multi-flop synchronizer (SYNC_STAGES deep, 2 by
// default) for a single asynchronous bit.
//   clk  in  destination clock
//   rst  in  asynchronous active-high reset, clears every stage
//   d    in  asynchronous input
//   q    out synchronized output
// ---------------------------------------------------------------------------
module bhg_sync2
  import bhg_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_r;

  // shift the asynchronous bit through the synchronizer chain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], d};
    end
  end

  assign q = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/bhg_sar_ctrl.sv
// ---------------------------------------------------------------------------
// bhg_sar_ctrl : successive-approximation ADC controller.
//   clk            in   system clock
//   rst            in   asynchronous active-high reset (aborts a conversion)
//   bus.start      in   request one conversion (sampled in IDLE only)
//   bus.cont       in   continuous mode, sampled in DONE
//   bus.cmp_in     in   raw asynchronous comparator output (1 = Vin >= Vdac)
//   bus.sample     out  track/hold switch control
//   bus.dac_code   out  trial code for the capacitor DAC
//   bus.busy       out  high in every state except IDLE
//   bus.result     out  last completed code
//   bus.valid      out  one-cycle strobe when result updates
// Parameters: WIDTH (>=2), SAMPLE_CYCLES (>=1), SETTLE_CYCLES (>=1).
// Each trial takes SETTLE_CYCLES+2 settle cycles (covering the synchronizer)
// plus one DECIDE cycle, so a conversion completes in
// SAMPLE_CYCLES + WIDTH*(SETTLE_CYCLES+3) + 1 cycles from the start edge.
// ---------------------------------------------------------------------------
module bhg_sar_ctrl
  import bhg_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  bhg_sar_ctrl_if.slave   bus
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_SAMPLE = ST_SAMPLE;
  localparam logic [2:0] S_SETTLE = ST_SETTLE;
  localparam logic [2:0] S_DECIDE = ST_DECIDE;
  localparam logic [2:0] S_DONE   = ST_DONE;

  localparam int CNT_W = $clog2(max2(SAMPLE_CYCLES, SETTLE_CYCLES + 2));
  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] IDX_MSB     = IDX_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_CODE    = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2:0]       state_r,  state_s;
  logic [CNT_W-1:0] cnt_r,    cnt_s;
  logic [IDX_W-1:0] idx_r,    idx_s;
  logic [WIDTH-1:0] code_r,   code_s;
  logic [WIDTH-1:0] result_r, result_s;
  logic             sample_r, sample_s;
  logic             busy_r,   busy_s;
  logic             valid_r,  valid_s;
  logic [WIDTH-1:0] trial_s;
  logic             cmp_s;

  bhg_sync2 u_cmp_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.cmp_in),
    .q   (cmp_s)
  );

  // next-state, phase counter, trial code and output-register logic
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    idx_s    = idx_r;
    code_s   = code_r;
    result_s = result_r;
    sample_s = sample_r;
    valid_s  = 1'b0;
    trial_s  = code_r;

    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_s  = S_SAMPLE;
          cnt_s    = {CNT_W{1'b0}};
          code_s   = {WIDTH{1'b0}};
          sample_s = 1'b1;
        end else begin
          state_s  = S_IDLE;
        end
      end

      S_SAMPLE: begin
        if (cnt_r == SAMPLE_LAST) begin
          state_s  = S_SETTLE;
          cnt_s    = {CNT_W{1'b0}};
          sample_s = 1'b0;
          code_s   = MSB_CODE;
          idx_s    = IDX_MSB;
        end else begin
          cnt_s    = cnt_r + 1'b1;
        end
      end

      S_SETTLE: begin
        if (cnt_r == SETTLE_LAST) begin
          state_s = S_DECIDE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          cnt_s   = cnt_r + 1'b1;
        end
      end

      S_DECIDE: begin
        // drop the bit under test if the DAC overshot, then arm the next one
        if (!cmp_s) begin
          trial_s[idx_r] = 1'b0;
        end else begin
          trial_s[idx_r] = 1'b1;
        end
        if (idx_r != {IDX_W{1'b0}}) begin
          trial_s[idx_r - 1'b1] = 1'b1;
          idx_s   = idx_r - 1'b1;
          state_s = S_SETTLE;
        end else begin
          state_s = S_DONE;
        end
        code_s = trial_s;
      end

      S_DONE: begin
        result_s = code_r;
        valid_s  = 1'b1;
        if (bus.cont) begin
          state_s  = S_SAMPLE;
          cnt_s    = {CNT_W{1'b0}};
          code_s   = {WIDTH{1'b0}};
          sample_s = 1'b1;
        end else begin
          state_s  = S_IDLE;
        end
      end

      default: begin
        state_s  = S_IDLE;
        cnt_s    = {CNT_W{1'b0}};
        code_s   = {WIDTH{1'b0}};
        sample_s = 1'b0;
      end
    endcase

    busy_s = (state_s != S_IDLE);
  end

  // controller state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      idx_r    <= {IDX_W{1'b0}};
      code_r   <= {WIDTH{1'b0}};
      result_r <= {WIDTH{1'b0}};
      sample_r <= 1'b0;
      busy_r   <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      idx_r    <= idx_s;
      code_r   <= code_s;
      result_r <= result_s;
      sample_r <= sample_s;
      busy_r   <= busy_s;
      valid_r  <= valid_s;
    end
  end

  assign bus.sample   = sample_r;
  assign bus.dac_code = code_r;
  assign bus.busy     = busy_r;
  assign bus.result   = result_r;
  assign bus.valid    = valid_r;

endmodule

// File: tb/tb_bhg_sar_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bhg_sar_ctrl : scoreboard bench for bhg_sar_ctrl with a skewed
// comparator model (cmp_in = vin >= dac_code, 0-1 cycle late).
// ---------------------------------------------------------------------------
module tb_bhg_sar_ctrl;

  localparam int W     = 8;
  localparam int SAMP  = 4;
  localparam int SETL  = 1;
  localparam int LAT   = SAMP + W * (SETL + 3) + 1;

  typedef struct {
    logic [W-1:0] code;
    int           cyc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [W-1:0]  vin;
  int            cyc;
  int            checks;
  int            errors;
  int            n_valid;
  logic          prev_busy;
  exp_t          exp_q[$];

  bhg_sar_ctrl_if #(.WIDTH(W)) bus();

  bhg_sar_ctrl #(
    .WIDTH         (W),
    .SAMPLE_CYCLES (SAMP),
    .SETTLE_CYCLES (SETL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference SAR: greedy binary weighing of vin, highest weight first.
  function automatic logic [W-1:0] ref_code(input int v);
    int code = 0;
    for (int w = 1 << (W - 1); w >= 1; w = w / 2)
      if (v >= code + w) code = code + w;
    return W'(code);
  endfunction

  // k-th trial code the DAC must present while converting v.
  function automatic logic [W-1:0] ref_trial(input int v, input int k);
    int code = 0;
    int w    = 1 << (W - 1);
    for (int i = 0; i < k; i++) begin
      if (v >= code + w) code = code + w;
      w = w / 2;
    end
    return W'(code + w);
  endfunction

  // comparator: either the current or the one-cycle-old decision
  initial begin
    logic c_old, c_cur;
    c_old = 1'b0;
    c_cur = 1'b0;
    bus.cmp_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      c_old = c_cur;
      c_cur = (vin >= bus.dac_code);
      bus.cmp_in = ($urandom_range(0, 1) == 1) ? c_old : c_cur;
    end
  end

  // monitor: every valid strobe is matched against the scoreboard
  initial begin
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.valid === 1'b1) begin
        n_valid++;
        check("busy_in_done", 32'(prev_busy), 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 32'(bus.valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("result", 32'(bus.result), 32'(e.code));
          check("latency", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_busy = bus.busy;
    end
  end

  // issue a one-cycle start pulse; returns at the negedge after the start edge
  task automatic start_conv();
    @(negedge clk);
    bus.start = 1'b1;
    exp_q.push_back('{code: ref_code(int'(vin)), cyc: cyc + 1 + LAT});
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_q.size() != 0 || bus.busy === 1'b1) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("quiet_timeout", 32'(n < 400), 32'd1);
  endtask

  task automatic wait_valid();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.valid !== 1'b1 && n < 200);
    check("valid_timeout", 32'(bus.valid), 32'd1);
  endtask

  initial begin
    int base;
    int s;
    logic [W-1:0] v3;
    cyc = 0; checks = 0; errors = 0; n_valid = 0;
    rst = 1'b1; vin = '0;
    bus.start = 1'b0; bus.cont = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_sample", 32'(bus.sample), 32'd0);
    check("rst_dac", 32'(bus.dac_code), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_valid", 32'(bus.valid), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: 0xA5, sample window and DAC trial sequence
    vin = 8'hA5;
    start_conv();
    for (int r = 0; r <= 34; r++) begin
      check("sample_window", 32'(bus.sample), 32'(r <= SAMP - 1));
      if (r >= 5 && (r - 5) % 4 == 0)
        check("dac_trial", 32'(bus.dac_code), 32'(ref_trial(int'(vin), (r - 5) / 4)));
      @(negedge clk);
    end
    wait_quiet();

    // 3: start pulses at cycles 5 and 20 are ignored
    vin = W'($urandom_range(0, 255));
    base = n_valid;
    start_conv();
    for (int r = 0; r <= 30; r++) begin
      bus.start = (r == 4 || r == 19) ? 1'b1 : 1'b0;
      check("busy_during_conv", 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    bus.start = 1'b0;
    wait_quiet();
    repeat (3) @(negedge clk);
    check("no_queued_start", 32'(bus.busy), 32'd0);
    check("one_valid", 32'(n_valid - base), 32'd1);

    // 2: extremes
    vin = 8'hFF; start_conv(); wait_quiet();
    vin = 8'h00; start_conv(); wait_quiet();

    // 4: reset mid-conversion
    vin = 8'h5A;
    start_conv();
    repeat (14) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_sample", 32'(bus.sample), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_dac", 32'(bus.dac_code), 32'd0);
    check("abort_result", 32'(bus.result), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    vin = W'($urandom_range(1, 254));
    start_conv();
    wait_quiet();

    // start held high: a new request each time IDLE is reached
    vin = W'($urandom_range(0, 255));
    @(negedge clk);
    bus.start = 1'b1;
    s = cyc;
    exp_q.push_back('{code: ref_code(int'(vin)), cyc: s + 1 + LAT});
    exp_q.push_back('{code: ref_code(int'(vin)), cyc: s + 2 + 2 * LAT});
    wait_valid();
    @(negedge clk);
    bus.start = 1'b0;
    wait_quiet();

    // 5/6: continuous mode, vin stepped, cont dropped in the third conversion
    v3 = W'($urandom_range(0, 255));
    bus.cont = 1'b1;
    vin = 8'h10;
    base = n_valid;
    @(negedge clk);
    bus.start = 1'b1;
    s = cyc;
    exp_q.push_back('{code: 8'h10, cyc: s + 1 + LAT});
    exp_q.push_back('{code: 8'hE0, cyc: s + 1 + 2 * LAT});
    exp_q.push_back('{code: ref_code(int'(v3)), cyc: s + 1 + 3 * LAT});
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid();
    vin = 8'hE0;
    wait_valid();
    vin = v3;
    repeat (15) @(negedge clk);
    bus.cont = 1'b0;
    wait_valid();
    @(negedge clk);
    check("idle_after_cont_drop", 32'(bus.busy), 32'd0);
    repeat (5) @(negedge clk);
    check("cont_valid_count", 32'(n_valid - base), 32'd3);
    check("stays_idle", 32'(bus.busy), 32'd0);

    // random single-shot conversions with random gaps
    for (int i = 0; i < 6; i++) begin
      vin = W'($urandom_range(0, 255));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      start_conv();
      wait_quiet();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
